// File: rtl/counter_sweep_ctrl.sv
// Sweep sequencer for a WIDTH-bit up/down counter: loads a start value, steps toward a
// target at a programmable rate and optionally bounces between the endpoints.
module counter_sweep_ctrl #(
    parameter int WIDTH      = 4,
    parameter int PRESCALE_W = 8,
    parameter int BOUNCE_W   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [WIDTH-1:0]      cmd_start,
    input  logic [WIDTH-1:0]      cmd_target,
    input  logic [PRESCALE_W-1:0] cmd_period,
    input  logic [BOUNCE_W-1:0]   cmd_bounces,
    input  logic                  abort,
    input  logic [WIDTH-1:0]      cnt_value,
    output logic                  cnt_load,
    output logic [WIDTH-1:0]      cnt_d_in,
    output logic                  cnt_up_down,
    output logic                  cnt_enable,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    typedef struct packed {
        logic [WIDTH-1:0]      start;
        logic [WIDTH-1:0]      target;
        logic [PRESCALE_W-1:0] period;
    } cmd_t;

    localparam logic [PRESCALE_W-1:0] PRESC_ONE  = PRESCALE_W'(1);
    localparam logic [BOUNCE_W-1:0]   BOUNCE_ONE = BOUNCE_W'(1);

    state_t                state_q, state_d;
    cmd_t                  cmd_q;
    logic [WIDTH-1:0]      endpoint_q;
    logic [PRESCALE_W-1:0] presc_q;
    logic [BOUNCE_W-1:0]   bounces_q;
    logic                  dir_q;

    logic tick, at_end, accept, reverse;

    assign tick    = (presc_q == cmd_q.period);
    assign at_end  = (cnt_value == endpoint_q);
    assign accept  = (state_q == IDLE) && cmd_valid;
    // A reversal consumes one RUN cycle at the endpoint; abort takes priority.
    assign reverse = (state_q == RUN) && !abort && at_end && (bounces_q != '0);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = LOAD;
            LOAD: state_d = abort ? IDLE : RUN;
            RUN: begin
                if (abort)
                    state_d = IDLE;
                else if (at_end && (bounces_q == '0))
                    state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Enable is combinational on cnt_value so a step is never issued at the endpoint.
    always_comb begin
        cmd_ready   = (state_q == IDLE);
        cnt_load    = (state_q == LOAD) && !abort;
        cnt_d_in    = (state_q == LOAD) ? cmd_q.start : '0;
        cnt_up_down = dir_q;
        cnt_enable  = (state_q == RUN) && !abort && tick && !at_end;
        busy        = (state_q == LOAD) || (state_q == RUN);
        done        = (state_q == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cmd_q      <= '0;
            endpoint_q <= '0;
            presc_q    <= '0;
            bounces_q  <= '0;
            dir_q      <= 1'b1;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        cmd_q.start  <= cmd_start;
                        cmd_q.target <= cmd_target;
                        cmd_q.period <= cmd_period;
                        bounces_q    <= cmd_bounces;
                        endpoint_q   <= cmd_target;
                        dir_q        <= (cmd_target >= cmd_start);
                    end
                end
                LOAD: presc_q <= '0;
                RUN: begin
                    if (reverse) begin
                        endpoint_q <= (endpoint_q == cmd_q.target) ? cmd_q.start : cmd_q.target;
                        dir_q      <= ~dir_q;
                        bounces_q  <= bounces_q - BOUNCE_ONE;
                        presc_q    <= '0;
                    end else begin
                        presc_q <= tick ? '0 : presc_q + PRESC_ONE;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_counter_sweep_ctrl.sv
// Bench for counter_sweep_ctrl: behavioural counter closes the loop, table-driven sweeps
// plus hand sequences for bounce timing, abort and reset.
module tb_counter_sweep_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_start, cmd_target;
    logic [7:0] cmd_period;
    logic [3:0] cmd_bounces;
    logic       abort;
    logic [3:0] cnt_value = '0;
    logic       cnt_load;
    logic [3:0] cnt_d_in;
    logic       cnt_up_down;
    logic       cnt_enable;
    logic       busy;
    logic       done;

    int tests = 0;
    int fails = 0;

    counter_sweep_ctrl #(.WIDTH(4), .PRESCALE_W(8), .BOUNCE_W(4)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_start(cmd_start), .cmd_target(cmd_target),
        .cmd_period(cmd_period), .cmd_bounces(cmd_bounces),
        .abort(abort), .cnt_value(cnt_value),
        .cnt_load(cnt_load), .cnt_d_in(cnt_d_in), .cnt_up_down(cnt_up_down),
        .cnt_enable(cnt_enable), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Plain wrapping up/down counter, as the real one would behave.
    always @(posedge clk) begin
        if (cnt_load)
            cnt_value <= cnt_d_in;
        else if (cnt_enable)
            cnt_value <= cnt_up_down ? cnt_value + 4'd1 : cnt_value - 4'd1;
    end

    typedef struct {
        logic [3:0] s;
        logic [3:0] t;
        logic [7:0] p;
        logic [3:0] b;
        int         en;
        int         done_cyc;
        int         fin;
        int         up;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, ".cmd_ready"},   int'(cmd_ready),   1);
        chk({tag, ".cnt_load"},    int'(cnt_load),    0);
        chk({tag, ".cnt_d_in"},    int'(cnt_d_in),    0);
        chk({tag, ".cnt_up_down"}, int'(cnt_up_down), 1);
        chk({tag, ".cnt_enable"},  int'(cnt_enable),  0);
        chk({tag, ".busy"},        int'(busy),        0);
        chk({tag, ".done"},        int'(done),        0);
    endtask

    // Cycle 0 is the accept cycle; called at its negedge, returns at cycle 1's negedge.
    task automatic issue(input string tag, input logic [3:0] s, input logic [3:0] t,
                         input logic [7:0] p, input logic [3:0] b);
        chk({tag, ".ready0"}, int'(cmd_ready), 1);
        cmd_valid = 1'b1; cmd_start = s; cmd_target = t; cmd_period = p; cmd_bounces = b;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic run_vec(input string tag, input vec_t v);
        int n_en = 0, n_load = 0, load_cyc = -1, n_done = 0, done_cyc = -1;
        int conflicts = 0, wraps = 0, busy_err = 0, up2 = -1, fin = -1, ready_after = -1;
        int prev = 0, diff;
        @(negedge clk);
        issue(tag, v.s, v.t, v.p, v.b);
        for (int cyc = 1; cyc <= 600; cyc++) begin
            if (cyc > 1) @(negedge clk);
            if (cnt_load) begin n_load++; load_cyc = cyc; end
            if (cnt_load && cnt_enable) conflicts++;
            if (cnt_enable) n_en++;
            if (cyc == 2) begin
                up2 = int'(cnt_up_down);
                prev = int'(cnt_value);
            end else if (cyc > 2) begin
                diff = int'(cnt_value) - prev;
                if (diff > 1 || diff < -1) wraps++;
                prev = int'(cnt_value);
            end
            if (done_cyc > 0 && cyc == done_cyc + 1) begin
                ready_after = int'(cmd_ready);
                break;
            end
            if (done) begin
                n_done++;
                if (busy) busy_err++;
                done_cyc = cyc;
                fin = int'(cnt_value);
            end else if (!busy) begin
                busy_err++;
            end
        end
        chk({tag, ".load_cyc"},    load_cyc,    1);
        chk({tag, ".n_load"},      n_load,      1);
        chk({tag, ".enables"},     n_en,        v.en);
        chk({tag, ".done_cyc"},    done_cyc,    v.done_cyc);
        chk({tag, ".done_pulses"}, n_done,      1);
        chk({tag, ".final_val"},   fin,         v.fin);
        chk({tag, ".up_down"},     up2,         v.up);
        chk({tag, ".ld_en_same"},  conflicts,   0);
        chk({tag, ".wrap"},        wraps,       0);
        chk({tag, ".busy"},        busy_err,    0);
        chk({tag, ".ready_after"}, ready_after, 1);
    endtask

    initial begin
        int exp_val[12];
        int exp_en[12];
        int exp_up[12];
        vec_t v2;

        // start, target, period, bounces, enables, done cycle, final value, up_down
        vecs[0] = '{4'd2,  4'd5,  8'd0,   4'd0,  3,  6,   5,  1};
        vecs[1] = '{4'd1,  4'd3,  8'd1,   4'd1,  4,  12,  1,  1};
        vecs[2] = '{4'd15, 4'd0,  8'd0,   4'd0,  15, 18,  0,  0};
        vecs[3] = '{4'd7,  4'd7,  8'd0,   4'd2,  0,  5,   7,  1};
        vecs[4] = '{4'd0,  4'd15, 8'd2,   4'd0,  15, 48,  15, 1};
        vecs[5] = '{4'd9,  4'd3,  8'd0,   4'd1,  12, 16,  9,  0};
        vecs[6] = '{4'd14, 4'd15, 8'd255, 4'd0,  1,  259, 15, 1};
        vecs[7] = '{4'd3,  4'd3,  8'd0,   4'd15, 0,  18,  3,  1};
        vecs[8] = '{4'd0,  4'd0,  8'd0,   4'd0,  0,  3,   0,  1};

        rst = 1'b1; cmd_valid = 1'b0; abort = 1'b0;
        cmd_start = '0; cmd_target = '0; cmd_period = '0; cmd_bounces = '0;
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        rst = 1'b0;

        for (int i = 0; i < 9; i++)
            run_vec($sformatf("vec%0d", i), vecs[i]);

        // Bounce timing, 1 -> 3 -> 1 at period 1: value/enable/direction per cycle 2..11.
        exp_val = '{0, 0, 1, 1, 2, 2, 3, 3, 3, 2, 2, 1};
        exp_en  = '{0, 0, 0, 1, 0, 1, 0, 0, 1, 0, 1, 0};
        exp_up  = '{0, 0, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0};
        @(negedge clk);
        issue("bnc", 4'd1, 4'd3, 8'd1, 4'd1);
        for (int c = 2; c < 12; c++) begin
            @(negedge clk);
            chk($sformatf("bnc.val@%0d", c), int'(cnt_value),   exp_val[c]);
            chk($sformatf("bnc.en@%0d", c),  int'(cnt_enable),  exp_en[c]);
            chk($sformatf("bnc.up@%0d", c),  int'(cnt_up_down), exp_up[c]);
        end
        @(negedge clk);
        chk("bnc.done@12", int'(done), 1);
        @(negedge clk);
        chk("bnc.done@13", int'(done), 0);

        // Abort on the third RUN cycle of 0 -> 9.
        @(negedge clk);
        issue("abt", 4'd0, 4'd9, 8'd0, 4'd0);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        abort = 1'b1;
        #1;
        chk("abt.enable", int'(cnt_enable), 0);
        chk("abt.val",    int'(cnt_value),  2);
        chk("abt.busy",   int'(busy),       1);
        @(negedge clk);
        abort = 1'b0;
        chk("abt.idle_busy",  int'(busy),      0);
        chk("abt.idle_ready", int'(cmd_ready), 1);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("abt.no_done%0d", k), int'(done),      0);
            chk($sformatf("abt.held%0d", k),    int'(cnt_value), 2);
            @(negedge clk);
        end
        v2 = '{4'd4, 4'd6, 8'd0, 4'd0, 2, 5, 6, 1};
        run_vec("abt.next", v2);

        // Reset mid-RUN, with a command pulsed while busy.
        @(negedge clk);
        issue("rst", 4'd0, 4'd15, 8'd0, 4'd0);
        @(negedge clk);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_start = 4'd9; cmd_target = 4'd1;
        chk("rst.ready_busy", int'(cmd_ready), 0);
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("rst.no_load", int'(cnt_load),  0);
        chk("rst.val4",    int'(cnt_value), 2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_reset_outputs("rst.after");
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("rst.idle_load%0d", k), int'(cnt_load),  0);
            chk($sformatf("rst.idle_done%0d", k), int'(done),      0);
            chk($sformatf("rst.idle_val%0d", k),  int'(cnt_value), 3);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
